kuznechik_byte_stream: RTL and testbench

Byte-stream front/back end for kuznechik_cipher. It packs 16 incoming bytes into one 128-bit block and issues it to the cipher over the request/busy handshake. It then captures the ciphered block on valid and acknowledges it. Finally it emits the result as 16 bytes on a valid/ready output stream. It sits directly upstream and downstream of the cipher core and replaces the bench-style driver with synthesizable RTL.

---
 rtl/kuznechik_pkg.sv | 29 ++
 rtl/kuznechik_block_buf.sv | 57 +++++
 rtl/kuznechik_byte_stream.sv | 149 ++++++++++++++
 tb/tb_kuznechik_byte_stream.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuznechik_pkg.sv
// Shared constants, FSM state type and byte-placement helper for the
// Kuznechik byte-stream front/back end.
//   BLOCK_W / BYTE_W / BYTES_PER_BLOCK / IDX_W : block geometry
//   stream_state_t                              : stream FSM states
//   byte_off()                                  : LSB offset of stream byte k
package kuznechik_pkg;

    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam int IDX_W           = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } stream_state_t;

    // Stream byte k lands at [127-8k -: 8] when MSB-first, else at [8k +: 8].
    // Returns the low bit of that byte lane so callers can use [off +: 8].
    function automatic int byte_off(input int idx, input bit msb_first);
        if (msb_first) begin
            return BLOCK_W - BYTE_W - BYTE_W * idx;
        end
        return BYTE_W * idx;
    endfunction

endpackage

// File: rtl/kuznechik_block_buf.sv
// 128-bit block buffer organised as 16 byte lanes.
//   clk, rst          : clock, asynchronous active-high reset (clears buffer)
//   load_byte_i       : write byte_i into lane byte_idx_i
//   load_block_i      : write all lanes from block_i (wins over load_byte_i)
//   rd_idx_i/rd_byte_o: read lane rd_idx_i
//   block_o           : whole buffer in block bit order
// Lane k always holds stream byte k; MSB_FIRST only decides where that lane
// sits inside the 128-bit block view.
module kuznechik_block_buf
    import kuznechik_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_byte_i,
    input  logic [IDX_W-1:0]   byte_idx_i,
    input  logic [BYTE_W-1:0]  byte_i,
    input  logic               load_block_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [BYTE_W-1:0]  rd_byte_o,
    output logic [BLOCK_W-1:0] block_o
);

    logic [BYTE_W-1:0] lanes [BYTES_PER_BLOCK];

    for (genvar gi = 0; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
        localparam int OFF = byte_off(gi, MSB_FIRST);

        logic [BYTE_W-1:0] lane_q;
        logic [BYTE_W-1:0] lane_d;

        always_comb begin
            lane_d = lane_q;
            if (load_block_i) begin
                lane_d = block_i[OFF +: BYTE_W];
            end else if (load_byte_i && (byte_idx_i == IDX_W'(gi))) begin
                lane_d = byte_i;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign lanes[gi]                 = lane_q;
        assign block_o[OFF +: BYTE_W]    = lane_q;
    end

    assign rd_byte_o = lanes[rd_idx_i];

endmodule

// File: rtl/kuznechik_byte_stream.sv
// Byte-stream wrapper around kuznechik_cipher.
//   s_*         : input byte stream (valid/ready), packed 16 bytes per block
//   cph_*       : cipher handshake (request/busy out, valid/ack back)
//   m_*         : output byte stream (valid/ready), 16 bytes per block
//   blocks_done_o : blocks fully drained, wraps modulo 2^CNT_W
//   err_o       : sticky, cipher asserted valid while not awaited
// Flow: FILL (collect 16 bytes) -> REQ (one-cycle request once cipher idle)
//       -> WAIT (ack + capture result) -> DRAIN (emit 16 bytes) -> FILL.
module kuznechik_byte_stream
    import kuznechik_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [7:0]         m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [127:0]       cph_data_o,
    output logic               cph_request_o,
    output logic               cph_ack_o,
    input  logic [127:0]       cph_data_i,
    input  logic               cph_valid_i,
    input  logic               cph_busy_i,
    output logic [CNT_W-1:0]   blocks_done_o,
    output logic               err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

    stream_state_t      state_q, state_d;
    logic [IDX_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   blocks_done_q, blocks_done_d;
    logic               err_q, err_d;

    logic               pack_load;
    logic               unpack_load;
    logic [BYTE_W-1:0]  unpack_byte;
    logic [BYTE_W-1:0]  pack_rd_unused;
    logic [BLOCK_W-1:0] unpack_blk_unused;

    kuznechik_block_buf #(.MSB_FIRST(MSB_FIRST)) u_pack (
        .clk          (clk),
        .rst          (rst),
        .load_byte_i  (pack_load),
        .byte_idx_i   (byte_cnt_q),
        .byte_i       (s_data_i),
        .load_block_i (1'b0),
        .block_i      ('0),
        .rd_idx_i     ('0),
        .rd_byte_o    (pack_rd_unused),
        .block_o      (cph_data_o)
    );

    kuznechik_block_buf #(.MSB_FIRST(MSB_FIRST)) u_unpack (
        .clk          (clk),
        .rst          (rst),
        .load_byte_i  (1'b0),
        .byte_idx_i   ('0),
        .byte_i       ('0),
        .load_block_i (unpack_load),
        .block_i      (cph_data_i),
        .rd_idx_i     (out_cnt_q),
        .rd_byte_o    (unpack_byte),
        .block_o      (unpack_blk_unused)
    );

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        out_cnt_d     = out_cnt_q;
        blocks_done_d = blocks_done_q;
        // A result is only legitimate while we are waiting for it.
        err_d         = err_q | (cph_valid_i & (state_q != ST_WAIT));
        s_ready_o     = 1'b0;
        cph_request_o = 1'b0;
        cph_ack_o     = 1'b0;
        m_valid_o     = 1'b0;
        pack_load     = 1'b0;
        unpack_load   = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    pack_load  = 1'b1;
                    // 4-bit counter wraps to 0 on the 16th byte.
                    byte_cnt_d = byte_cnt_q + IDX_W'(1);
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // The cipher only samples request while idle, so holding off
                // here keeps the request a single cycle.
                if (!cph_busy_i) begin
                    cph_request_o = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cph_valid_i) begin
                    cph_ack_o   = 1'b1;
                    unpack_load = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    out_cnt_d = out_cnt_q + IDX_W'(1);
                    if (out_cnt_q == LAST_IDX) begin
                        blocks_done_d = blocks_done_q + CNT_W'(1);
                        state_d       = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            byte_cnt_q    <= '0;
            out_cnt_q     <= '0;
            blocks_done_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            out_cnt_q     <= out_cnt_d;
            blocks_done_q <= blocks_done_d;
            err_q         <= err_d;
        end
    end

    // Outside DRAIN the byte port reads zero rather than stale result data.
    assign m_data_o      = (state_q == ST_DRAIN) ? unpack_byte : '0;
    assign blocks_done_o = blocks_done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_kuznechik_byte_stream.sv
// Self-checking bench for kuznechik_byte_stream with a behavioural cipher
// stub (result = ~plaintext, about 5 cycles latency).
module tb_kuznechik_byte_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [127:0] cph_data_o;
    logic         cph_req;
    logic         cph_ack;
    logic [127:0] cph_data_i;
    logic         cph_valid;
    logic         cph_busy;
    logic [15:0]  blocks_done;
    logic         err;

    // second instance, LSB-first, with an idle cipher port
    logic         lsb_valid = 1'b0;
    logic         lsb_s_ready;
    logic [7:0]   lsb_m_data;
    logic         lsb_m_valid;
    logic [127:0] lsb_cph_data;
    logic         lsb_req;
    logic         lsb_ack;
    logic [15:0]  lsb_blocks;
    logic         lsb_err;

    // cipher stub
    logic         stub_busy, stub_valid;
    logic [127:0] stub_held, stub_out;
    logic [2:0]   stub_lat;
    logic         force_busy = 1'b0;
    logic         spur_valid = 1'b0;

    assign cph_busy   = stub_busy | force_busy;
    assign cph_valid  = stub_valid | spur_valid;
    assign cph_data_i = stub_out;

    always #5 clk = ~clk;

    kuznechik_byte_stream #(.MSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .cph_data_o(cph_data_o), .cph_request_o(cph_req), .cph_ack_o(cph_ack),
        .cph_data_i(cph_data_i), .cph_valid_i(cph_valid), .cph_busy_i(cph_busy),
        .blocks_done_o(blocks_done), .err_o(err)
    );

    kuznechik_byte_stream #(.MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_valid_i(lsb_valid), .s_ready_o(lsb_s_ready),
        .m_data_o(lsb_m_data), .m_valid_o(lsb_m_valid), .m_ready_i(m_ready),
        .cph_data_o(lsb_cph_data), .cph_request_o(lsb_req), .cph_ack_o(lsb_ack),
        .cph_data_i(128'h0), .cph_valid_i(1'b0), .cph_busy_i(1'b0),
        .blocks_done_o(lsb_blocks), .err_o(lsb_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            stub_valid <= 1'b0;
            stub_held  <= '0;
            stub_out   <= '0;
            stub_lat   <= '0;
        end else if (stub_valid && cph_ack) begin
            stub_valid <= 1'b0;
            stub_busy  <= 1'b0;
        end else if (stub_busy && !stub_valid) begin
            if (stub_lat == 3'd0) begin
                stub_valid <= 1'b1;
                stub_out   <= ~stub_held;
            end else begin
                stub_lat <= stub_lat - 3'd1;
            end
        end else if (cph_req) begin
            stub_busy <= 1'b1;
            stub_held <= cph_data_o;
            stub_lat  <= 3'd4;
        end
    end

    // ---------------- bench state ----------------
    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [11];

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_blk_q [$];
    logic [7:0]   exp_byte_q [$];

    logic       s_req, s_ack, s_acc;
    logic       prev_ack = 1'b0;
    logic       stalled_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic       in_flight = 1'b0;
    int         fill_cnt = 0;
    int         blk_out_cnt = 0;
    int         out_total = 0;
    int         req_cnt = 0;
    int         ack_cnt = 0;
    int         cyc_n = 0;
    logic       bp_mode = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;   // m_ready sequence 1,0,0,1 (bit i = cycle i)

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge (what the coming posedge acts on), then
    // return just after the posedge so the caller can drive new inputs.
    task automatic cycle();
        logic [7:0] eb;
        @(negedge clk);
        s_req = cph_req;
        s_ack = cph_ack;
        s_acc = s_valid & s_ready;

        if (in_flight) chk("s_ready_low_in_flight", {127'd0, s_ready}, 128'd0);
        if (s_acc) begin
            fill_cnt++;
            if (fill_cnt == 16) begin
                fill_cnt  = 0;
                in_flight = 1'b1;
            end
        end

        if (prev_ack) chk("ack_to_mvalid", {127'd0, m_valid}, 128'd1);
        prev_ack = cph_ack;
        if (cph_ack) ack_cnt++;

        if (cph_req) begin
            req_cnt++;
            if (exp_blk_q.size() == 0) begin
                chk("unexpected_req", {127'd0, cph_req}, 128'd0);
            end else begin
                chk("cph_data_o", cph_data_o, exp_blk_q.pop_front());
                $display("request block %032h", cph_data_o);
            end
        end

        if (stalled_prev && m_valid) chk("m_data_stable", {120'd0, m_data}, {120'd0, stall_data});
        stalled_prev = m_valid & ~m_ready;
        stall_data   = m_data;

        if (m_valid && m_ready) begin
            out_total++;
            if (exp_byte_q.size() == 0) begin
                chk("unexpected_byte", {127'd0, m_valid}, 128'd0);
            end else begin
                eb = exp_byte_q.pop_front();
                chk("m_data_o", {120'd0, m_data}, {120'd0, eb});
            end
            blk_out_cnt++;
            if (blk_out_cnt == 16) begin
                blk_out_cnt = 0;
                in_flight   = 1'b0;
                $display("drained block, blocks_done will be %0d", blocks_done + 16'd1);
            end
        end

        @(posedge clk);
        #1;
        cyc_n++;
        m_ready = bp_mode ? rdy_pat[cyc_n % 4] : 1'b1;
    endtask

    task automatic send_bytes(input logic [127:0] pt, input int first, input int last);
        int n;
        for (int k = first; k <= last; k++) begin
            s_data  = pt[127 - 8*k -: 8];
            s_valid = 1'b1;
            n = 0;
            do begin
                cycle();
                n++;
            end while (!s_acc && n < 300);
            chk("byte_accepted", {127'd0, s_acc}, 128'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [127:0] pt, input logic [127:0] ct);
        exp_blk_q.push_back(pt);
        for (int k = 0; k < 16; k++) exp_byte_q.push_back(ct[127 - 8*k -: 8]);
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] ct);
        push_exp(pt, ct);
        send_bytes(pt, 0, 15);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_byte_q.size() != 0 || in_flight) && n < 3000) begin
            cycle();
            n++;
        end
        chk("drain_done", {127'd0, (exp_byte_q.size() == 0 && !in_flight)}, 128'd1);
    endtask

    task automatic tb_flush();
        exp_blk_q.delete();
        exp_byte_q.delete();
        in_flight    = 1'b0;
        fill_cnt     = 0;
        blk_out_cnt  = 0;
        prev_ack     = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic chk_reset_values();
        chk("rst_s_ready",     {127'd0, s_ready},   128'd1);
        chk("rst_m_valid",     {127'd0, m_valid},   128'd0);
        chk("rst_m_data",      {120'd0, m_data},    128'd0);
        chk("rst_cph_request", {127'd0, cph_req},   128'd0);
        chk("rst_cph_ack",     {127'd0, cph_ack},   128'd0);
        chk("rst_cph_data",    cph_data_o,          128'd0);
        chk("rst_blocks_done", {112'd0, blocks_done}, 128'd0);
        chk("rst_err",         {127'd0, err},       128'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_flush();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        logic [127:0] lsb_exp;

        vecs[0]  = '{128'hc177d2d35af6d17477545bfcf97d43a4, 128'h3e882d2ca5092e8b88aba4030682bc5b};
        vecs[1]  = '{128'h1b877fafa3ba0026e8ef95de495ac74c, 128'he47880505c45ffd917106a21b6a538b3};
        vecs[10] = '{128'h44bf130e7bcab6a1d2d867280bb89269, 128'hbb40ecf18435495e2d2798d7f4476d96};
        vecs[2].pt = 128'h00112233445566778899aabbccddeeff;
        vecs[3].pt = 128'hffffffffffffffffffffffffffffffff;
        vecs[4].pt = 128'h00000000000000000000000000000000;
        vecs[5].pt = 128'h0123456789abcdeffedcba9876543210;
        vecs[6].pt = 128'h8000000000000000000000000000000_1;
        vecs[7].pt = 128'hdeadbeefcafef00d0badc0de12345678;
        vecs[8].pt = 128'h5a5aa5a55a5aa5a5a5a55a5aa5a55a5a;
        vecs[9].pt = 128'h7f8e9dacbbcad9e8f70615243342516f;
        for (int i = 2; i < 10; i++) vecs[i].ct = ~vecs[i].pt;

        rst = 1'b1;
        #1;
        chk_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single block and request latency
        send_block(vecs[0].pt, vecs[0].ct);
        cycle();
        chk("req_1cycle_after_16th", {127'd0, s_req}, 128'd1);
        wait_drain();
        chk("blocks_done_1", {112'd0, blocks_done}, 128'd1);

        // busy hold: no request while busy, one pulse on first idle cycle
        force_busy = 1'b1;
        snap = req_cnt;
        send_block(vecs[1].pt, vecs[1].ct);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("no_req_while_busy", {127'd0, s_req}, 128'd0);
        end
        force_busy = 1'b0;
        cycle();
        chk("req_when_idle", {127'd0, s_req}, 128'd1);
        cycle();
        chk("req_single_pulse", {127'd0, s_req}, 128'd0);
        wait_drain();
        chk("busy_req_count", req_cnt - snap, 128'd1);
        chk("blocks_done_2", {112'd0, blocks_done}, 128'd2);

        // output backpressure
        bp_mode = 1'b1;
        snap = out_total;
        send_block(vecs[5].pt, vecs[5].ct);
        wait_drain();
        bp_mode = 1'b0;
        chk("bp_byte_count", out_total - snap, 128'd16);
        chk("blocks_done_3", {112'd0, blocks_done}, 128'd3);

        // eleven back-to-back blocks
        do_reset();
        snap = out_total;
        for (int i = 0; i < 11; i++) send_block(vecs[i].pt, vecs[i].ct);
        wait_drain();
        chk("b2b_byte_count", out_total - snap, 128'd176);
        chk("blocks_done_11", {112'd0, blocks_done}, 128'd11);

        // reset while waiting for the cipher, then a fresh block
        send_block(vecs[7].pt, vecs[7].ct);
        n = 0;
        while (!s_req && n < 50) begin
            cycle();
            n++;
        end
        chk("abort_req_seen", {127'd0, s_req}, 128'd1);
        cycle();
        cycle();
        snap = ack_cnt;
        do_reset();
        chk("abort_no_ack", ack_cnt - snap, 128'd0);
        send_block(vecs[8].pt, vecs[8].ct);
        wait_drain();
        chk("post_abort_blocks_done", {112'd0, blocks_done}, 128'd1);
        chk("post_abort_err", {127'd0, err}, 128'd0);

        // spurious cipher valid during FILL
        push_exp(vecs[9].pt, vecs[9].ct);
        send_bytes(vecs[9].pt, 0, 4);
        spur_valid = 1'b1;
        snap = ack_cnt;
        cycle();
        spur_valid = 1'b0;
        chk("spur_no_ack", {127'd0, s_ack}, 128'd0);
        cycle();
        chk("spur_err_set", {127'd0, err}, 128'd1);
        send_bytes(vecs[9].pt, 5, 15);
        cycle();
        chk("spur_fill_count_kept", {127'd0, s_req}, 128'd1);
        wait_drain();
        chk("spur_ack_count", ack_cnt - snap, 128'd1);
        chk("spur_err_sticky", {127'd0, err}, 128'd1);

        // LSB-first byte placement on the second instance
        for (int k = 0; k < 16; k++) lsb_exp[8*k +: 8] = vecs[0].pt[127 - 8*k -: 8];
        for (int k = 0; k < 16; k++) begin
            s_data    = vecs[0].pt[127 - 8*k -: 8];
            lsb_valid = 1'b1;
            cycle();
        end
        lsb_valid = 1'b0;
        cycle();
        chk("lsb_first_byte", {120'd0, lsb_cph_data[7:0]}, 128'hc1);
        chk("lsb_block", lsb_cph_data, lsb_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
